// File: rtl/r2sdf_seq_ctrl_if.sv
// r2sdf_seq_ctrl_if: control bundle between the R2SDF sequencer and its host/datapath.
//   master: sequencer side; receives start, flush, in_valid and drives
//           in_ready, adv, zero_fill, stage_sel, stage_en, tw_idx,
//           out_valid, out_idx, frame_done, busy.
//   slave : host/datapath side, the mirror image of master.
interface r2sdf_seq_ctrl_if #(
    parameter int N    = 3,
    parameter int TW_W = N - 1
);
    logic              start;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              adv;
    logic              zero_fill;
    logic [N-1:0]      stage_sel;
    logic [N-1:0]      stage_en;
    logic [N*TW_W-1:0] tw_idx;
    logic              out_valid;
    logic [N-1:0]      out_idx;
    logic              frame_done;
    logic              busy;

    modport master (
        input  start, flush, in_valid,
        output in_ready, adv, zero_fill, stage_sel, stage_en, tw_idx,
               out_valid, out_idx, frame_done, busy
    );

    modport slave (
        output start, flush, in_valid,
        input  in_ready, adv, zero_fill, stage_sel, stage_en, tw_idx,
               out_valid, out_idx, frame_done, busy
    );
endinterface

// File: rtl/r2sdf_seq_ctrl.sv
// r2sdf_seq_ctrl: central sequencer for an N-stage radix-2 SDF FFT pipeline.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.master : start/flush/in_valid in; in_ready, adv, zero_fill, per-stage
//                stage_sel/stage_en/tw_idx, out_valid/out_idx/frame_done, busy out
//   R2SDF_BITREV_IDX_EN: when defined, out_idx is the bit-reversed output
//                        count (natural frequency bin); otherwise the raw count.
module r2sdf_seq_ctrl #(
    parameter int N    = 3,
    parameter int TW_W = N - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    r2sdf_seq_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    localparam int             M      = 1 << N;
    localparam logic [N-1:0]   ONE    = N'(1);
    localparam logic [N-1:0]   LAST   = N'(M - 1);
    localparam logic [N-1:0]   PENULT = N'(M - 2);

    state_t            state, state_nx;
    logic              in_ready, adv, zero_fill, busy, arm, out_valid;
    logic [N-1:0]      cnt, fill_cnt, flush_cnt, out_cnt;
    logic [N-1:0]      stage_en, set_en, stage_sel, out_idx;
    logic [N*TW_W-1:0] tw_idx;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.start ? FILL : IDLE;
            FILL:    state_nx = (adv && fill_cnt == PENULT) ? RUN : FILL;
            RUN:     state_nx = bus.flush ? FLUSH : RUN;
            FLUSH:   state_nx = (flush_cnt == PENULT) ? IDLE : FLUSH;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state == FILL || state == RUN;
        zero_fill = state == FLUSH;
        busy      = state != IDLE;
        adv       = (in_ready && bus.in_valid) || zero_fill;
        arm       = state == IDLE && bus.start;
    end

    // fill_cnt saturates once the pipeline is full; from then on every adv emits an output
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt       <= '0;
            fill_cnt  <= '0;
            flush_cnt <= '0;
            out_cnt   <= '0;
            out_valid <= 1'b0;
            stage_en  <= '0;
        end else begin
            cnt       <= arm ? '0 : cnt + (adv ? ONE : '0);
            fill_cnt  <= arm ? '0 : (adv && fill_cnt != LAST) ? fill_cnt + ONE : fill_cnt;
            flush_cnt <= zero_fill ? flush_cnt + ONE : '0;
            out_cnt   <= arm ? '0 : out_cnt + (out_valid ? ONE : '0);
            out_valid <= adv && fill_cnt == LAST;
            stage_en  <= (zero_fill && flush_cnt == PENULT) ? '0 : stage_en | set_en;
        end

    // Stage k sees the stream offset by its prefix latency; its local count
    // picks load vs butterfly (MSB of the 2*D_k block) and the twiddle exponent.
    for (genvar k = 1; k <= N; k++) begin : g_stage
        localparam logic [N-1:0] LK   = N'(M - (1 << (N - k + 1)));
        localparam logic [N-1:0] MASK = N'((1 << (N - k)) - 1);
        logic [N-1:0] ck;
        assign ck                         = cnt - LK;
        assign stage_sel[k-1]             = ck[N-k];
        assign tw_idx[(k-1)*TW_W +: TW_W] = TW_W'((ck & MASK) << (k - 1));
        if (k == 1) begin : g_first
            assign set_en[k-1] = adv;
        end else begin : g_rest
            assign set_en[k-1] = adv && fill_cnt >= LK;
        end
    end

`ifdef R2SDF_BITREV_IDX_EN
    always_comb begin
        out_idx = '0;
        for (int i = 0; i < N; i++) out_idx[i] = out_cnt[N-1-i];
    end
`else
    assign out_idx = out_cnt;
`endif

    assign bus.in_ready   = in_ready;
    assign bus.adv        = adv;
    assign bus.zero_fill  = zero_fill;
    assign bus.busy       = busy;
    assign bus.stage_sel  = stage_sel;
    assign bus.stage_en   = stage_en;
    assign bus.tw_idx     = tw_idx;
    assign bus.out_valid  = out_valid;
    assign bus.out_idx    = out_idx;
    assign bus.frame_done = out_valid && out_cnt == LAST;
endmodule
